// File: rtl/wash_cycle_sequencer_if.sv
// Handshake bundle between the wash-cycle sequencer, its coin/panel controls and the
// downstream phase timer.
interface wash_cycle_sequencer_if;
    logic        coin_in;
    logic        cancel;
    logic        double_wash;
    logic        current_programm_done;
    logic [31:0] value;
    logic        next_programm_started;
    logic [2:0]  phase;
    logic        door_lock;
    logic        wash_done;

    // master: panel/timer side that drives requests and consumes phase outputs
    modport master (
        output coin_in, cancel, double_wash, current_programm_done,
        input  value, next_programm_started, phase, door_lock, wash_done
    );

    // slave: the sequencer itself
    modport slave (
        input  coin_in, cancel, double_wash, current_programm_done,
        output value, next_programm_started, phase, door_lock, wash_done
    );
endinterface

// File: rtl/wash_cycle_sequencer.sv
// Wash program sequencer: FILL -> WASH -> RINSE -> SPIN -> IDLE, loading the phase timer.
// Optional second WASH+RINSE pass is compiled in with `define WCS_DOUBLE_WASH_EN.
module wash_cycle_sequencer #(
    parameter int unsigned FILL_TICKS  = 60,
    parameter int unsigned WASH_TICKS  = 300,
    parameter int unsigned RINSE_TICKS = 120,
    parameter int unsigned SPIN_TICKS  = 60
) (
    input logic                   clk,
    input logic                   rst,
    wash_cycle_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_FILL  = 3'd1,
        PH_WASH  = 3'd2,
        PH_RINSE = 3'd3,
        PH_SPIN  = 3'd4
    } phase_e;

    phase_e      phase_q, phase_d, target;
    logic [31:0] value_q, value_d;
    logic        start_q, start_d;
    logic        done_q, done_d;
    logic        lock_q, lock_d;
    logic [1:0]  guard_q, guard_d;
    logic        enter, done_ok, cancel_ok;
`ifdef WCS_DOUBLE_WASH_EN
    logic        dw_q, dw_d;
    logic        pass_q, pass_d;
`endif

    function automatic logic [31:0] ticks_for(input phase_e p);
        case (p)
            PH_FILL:  return FILL_TICKS;
            PH_WASH:  return WASH_TICKS;
            PH_RINSE: return RINSE_TICKS;
            PH_SPIN:  return SPIN_TICKS;
            default:  return 32'd0;
        endcase
    endfunction

    // The guard hides the done level left over from the previous phase.
    assign done_ok   = bus.current_programm_done && (guard_q == 2'd0);
    // Cancel is held off for the pulse cycle so start pulses never land back to back.
    assign cancel_ok = bus.cancel && !start_q;

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        phase_d = phase_q;
        value_d = value_q;
        start_d = 1'b0;
        done_d  = 1'b0;
        guard_d = (guard_q != 2'd0) ? guard_q - 2'd1 : 2'd0;
        enter   = 1'b0;
        target  = phase_q;
`ifdef WCS_DOUBLE_WASH_EN
        dw_d    = dw_q;
        pass_d  = pass_q;
`endif
        case (phase_q)
            PH_IDLE: begin
                if (bus.coin_in && !bus.cancel) begin
                    enter  = 1'b1;
                    target = PH_FILL;
`ifdef WCS_DOUBLE_WASH_EN
                    dw_d   = bus.double_wash;
                    pass_d = 1'b0;
`endif
                end
            end
            PH_FILL, PH_WASH: begin
                if (cancel_ok) begin
                    enter  = 1'b1;
                    target = PH_SPIN;
                end else if (done_ok) begin
                    enter  = 1'b1;
                    target = (phase_q == PH_FILL) ? PH_WASH : PH_RINSE;
                end
            end
            PH_RINSE: begin
                if (cancel_ok) begin
                    enter  = 1'b1;
                    target = PH_SPIN;
                end else if (done_ok) begin
                    enter  = 1'b1;
                    target = PH_SPIN;
`ifdef WCS_DOUBLE_WASH_EN
                    if (dw_q && !pass_q) begin
                        target = PH_WASH;
                        pass_d = 1'b1;
                    end
`endif
                end
            end
            PH_SPIN: begin
                if (done_ok) begin
                    phase_d = PH_IDLE;
                    value_d = 32'd0;
                    done_d  = 1'b1;
`ifdef WCS_DOUBLE_WASH_EN
                    pass_d  = 1'b0;
`endif
                end
            end
            default: begin
                phase_d = PH_IDLE;
                value_d = 32'd0;
                guard_d = 2'd0;
`ifdef WCS_DOUBLE_WASH_EN
                dw_d    = 1'b0;
                pass_d  = 1'b0;
`endif
            end
        endcase

        if (enter) begin
            phase_d = target;
            value_d = ticks_for(target);
            start_d = 1'b1;
            guard_d = 2'd2;
        end
        lock_d = (phase_d != PH_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= PH_IDLE;
            value_q <= 32'd0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            lock_q  <= 1'b0;
            guard_q <= 2'd0;
`ifdef WCS_DOUBLE_WASH_EN
            dw_q    <= 1'b0;
            pass_q  <= 1'b0;
`endif
        end else begin
            phase_q <= phase_d;
            value_q <= value_d;
            start_q <= start_d;
            done_q  <= done_d;
            lock_q  <= lock_d;
            guard_q <= guard_d;
`ifdef WCS_DOUBLE_WASH_EN
            dw_q    <= dw_d;
            pass_q  <= pass_d;
`endif
        end
    end

    assign bus.value                 = value_q;
    assign bus.next_programm_started = start_q;
    assign bus.phase                 = phase_q;
    assign bus.door_lock             = lock_q;
    assign bus.wash_done             = done_q;

endmodule
